// File: rtl/conversor_formato_pkg.sv
// Shared constants for the fixed-point format converter.
//   ANCHO       legacy input sample width
//   RESOLUCION  legacy input fractional bits
//   DOBLEANCHO  legacy output sample width
//   state_e     control states of the converter (IDLE / EMIT)
package conversor_formato_pkg;

  localparam int ANCHO      = 16;
  localparam int RESOLUCION = 8;
  localparam int DOBLEANCHO = 2 * ANCHO;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/conversor_formato_convertidor_fx.sv
// convertidor_fx: combinational conversion of one two's-complement sample
// from IN_W/IN_FRAC to OUT_W/OUT_FRAC.
//   sample    input sample
//   round_en  1 = round half up, 0 = truncate toward -inf
//   sat_en    1 = saturate, 0 = wrap when the integer part overflows
//   value     converted sample
//   ovf       integer part did not fit OUT_W
module convertidor_fx #(
  parameter int IN_W     = 16,
  parameter int IN_FRAC  = 8,
  parameter int OUT_W    = 32,
  parameter int OUT_FRAC = 16
) (
  input  logic [IN_W-1:0]  sample,
  input  logic             round_en,
  input  logic             sat_en,
  output logic [OUT_W-1:0] value,
  output logic             ovf
);

  localparam int SH = (OUT_FRAC >= IN_FRAC) ? OUT_FRAC - IN_FRAC : 0;
  localparam int D  = (IN_FRAC > OUT_FRAC) ? IN_FRAC - OUT_FRAC : 0;
  // Wide enough for the rounding carry, the left shift and the range check.
  localparam int WW = IN_W + 1 + SH + OUT_W;
  // Half an output LSB; zero when no bits are dropped, so rounding is a no-op.
  localparam logic signed [WW-1:0] HALF = (WW'(1) << D) >> 1;

  logic signed [WW-1:0] ext;
  logic signed [WW-1:0] aligned;
  logic                 fits;

  always_comb begin
    ext = {{(WW-IN_W){sample[IN_W-1]}}, sample};
    if (round_en) begin
      ext = ext + HALF;
    end
    aligned = (ext >>> D) <<< SH;
    // Fits when every bit from the output sign bit upward agrees.
    fits = (aligned[WW-1:OUT_W-1] == '0) || (aligned[WW-1:OUT_W-1] == '1);
    ovf  = !fits;
    if (fits || !sat_en) begin
      value = aligned[OUT_W-1:0];
    end else if (aligned[WW-1]) begin
      value = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      value = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/conversor_formato.sv
// conversor_formato: accepts a vector of CH samples and emits them one per
// out_ready handshake, each converted by convertidor_fx.
//   clk, reset_n           clock, async active-low reset
//   in_valid/in_ready      vector handshake; in_data channel k at [k*IN_W +: IN_W]
//   round_en, sat_en       conversion mode, captured with the vector
//   out_valid/out_ready    sample handshake
//   out_data, out_ch       converted sample and its channel index
//   out_last, out_ovf      last channel flag, per-sample overflow flag
//   ovf_sticky, clr_ovf    accumulated overflow flag and its clear
module conversor_formato
  import conversor_formato_pkg::*;
#(
  parameter  int CH       = 4,
  parameter  int IN_W     = ANCHO,
  parameter  int IN_FRAC  = RESOLUCION,
  parameter  int OUT_W    = DOBLEANCHO,
  parameter  int OUT_FRAC = 2 * RESOLUCION,
  localparam int CW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH*IN_W-1:0] in_data,
  input  logic               round_en,
  input  logic               sat_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [CW-1:0]      out_ch,
  output logic               out_last,
  output logic               out_ovf,
  output logic               ovf_sticky,
  input  logic               clr_ovf
);

  state_e              state_q, state_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [CH*IN_W-1:0]  buf_q, buf_d;
  logic                round_q, round_d;
  logic                sat_q, sat_d;
  logic                sticky_q, sticky_d;

  logic                emit;
  logic                last;
  logic                accept;
  logic [IN_W-1:0]     sample;
  logic [OUT_W-1:0]    conv_value;
  logic                conv_ovf;

  assign emit   = (state_q == EMIT);
  assign last   = emit && (idx_q == CW'(CH - 1));
  assign accept = in_valid && in_ready;

  always_comb begin
    sample = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (idx_q == CW'(k)) begin
        sample = buf_q[k*IN_W +: IN_W];
      end
    end
  end

  convertidor_fx #(
    .IN_W    (IN_W),
    .IN_FRAC (IN_FRAC),
    .OUT_W   (OUT_W),
    .OUT_FRAC(OUT_FRAC)
  ) u_conv (
    .sample  (sample),
    .round_en(round_q),
    .sat_en  (sat_q),
    .value   (conv_value),
    .ovf     (conv_ovf)
  );

  assign in_ready   = !emit || (last && out_ready);
  assign out_valid  = emit;
  assign out_ch     = emit ? idx_q : '0;
  assign out_last   = last;
  assign out_data   = emit ? conv_value : '0;
  assign out_ovf    = emit && conv_ovf;
  assign ovf_sticky = sticky_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    round_d  = round_q;
    sat_d    = sat_q;
    sticky_d = sticky_q;

    if (emit && out_ready) begin
      if (last) begin
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    // An accept on the last handshake overrides the return to IDLE.
    if (accept) begin
      state_d = EMIT;
      idx_d   = '0;
      buf_d   = in_data;
      round_d = round_en;
      sat_d   = sat_en;
    end

    // Set takes priority over clear.
    if (clr_ovf) begin
      sticky_d = 1'b0;
    end
    if (out_valid && out_ready && out_ovf) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      buf_q    <= '0;
      round_q  <= 1'b0;
      sat_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
      round_q  <= round_d;
      sat_q    <= sat_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_conversor_formato.sv
// Self-checking bench for conversor_formato: behavioural model + scoreboard,
// directed corner vectors and randomized traffic.
module tb_conversor_formato;

  localparam int CH = 4, IN_W = 16, IN_FRAC = 8, OUT_W = 8, OUT_FRAC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n;
  logic               in_valid, in_ready, round_en, sat_en;
  logic [CH*IN_W-1:0] in_data;
  logic               out_valid, out_ready, out_last, out_ovf, ovf_sticky, clr_ovf;
  logic [OUT_W-1:0]   out_data;
  logic [1:0]         out_ch;

  logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
  logic [15:0] d2_in_data;
  logic [15:0] d2_out_data;
  logic        d2_out_ch, d2_out_last, d2_out_ovf, d2_ovf_sticky;

  conversor_formato #(
    .CH(CH), .IN_W(IN_W), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .round_en(round_en), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .out_ovf(out_ovf),
    .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
  );

  conversor_formato #(
    .CH(2), .IN_W(8), .IN_FRAC(4), .OUT_W(16), .OUT_FRAC(8)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_data(d2_in_data), .round_en(1'b0), .sat_en(1'b0),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data),
    .out_ch(d2_out_ch), .out_last(d2_out_last), .out_ovf(d2_out_ovf),
    .ovf_sticky(d2_ovf_sticky), .clr_ovf(1'b0)
  );

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on real integers: scale by 2^(out_frac-in_frac),
  // floor division when dropping bits, then clamp or wrap into out_w bits.
  function automatic longint conv_model(input longint x, input int in_frac, input int out_w,
                                        input int out_frac, input bit rnd, input bit sat,
                                        output bit ovf);
    longint v, mx, mn;
    int d;
    if (out_frac >= in_frac) begin
      v = x * (longint'(1) << (out_frac - in_frac));
    end else begin
      d = in_frac - out_frac;
      if (rnd) x = x + (longint'(1) << (d - 1));
      v = x >>> d;
    end
    mx  = (longint'(1) << (out_w - 1)) - 1;
    mn  = -mx - 1;
    ovf = (v > mx) || (v < mn);
    if (ovf && sat) v = (v > mx) ? mx : mn;
    return v & ((longint'(1) << out_w) - 1);
  endfunction

  function automatic longint sx16(input logic [15:0] v);
    logic signed [15:0] s;
    s = v;
    return longint'(s);
  endfunction

  function automatic longint sx8(input logic [7:0] v);
    logic signed [7:0] s;
    s = v;
    return longint'(s);
  endfunction

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [1:0]       ch;
    logic             last;
    logic             ovf;
  } exp_t;

  exp_t q[$];
  bit   sticky_m = 1'b0;
  bit   mon_en = 1'b0;
  int   hs_cnt = 0;

  function automatic void push_vector(input logic [CH*IN_W-1:0] d, input bit r, input bit s);
    exp_t e;
    bit   o;
    for (int k = 0; k < CH; k++) begin
      e.data = OUT_W'(conv_model(sx16(d[k*IN_W +: IN_W]), IN_FRAC, OUT_W, OUT_FRAC, r, s, o));
      e.ch   = 2'(k);
      e.last = (k == CH - 1);
      e.ovf  = o;
      q.push_back(e);
    end
  endfunction

  // Scoreboard: one pass per cycle at the falling edge.
  always @(negedge clk) begin
    bit exp_valid, exp_ready, nxt;
    if (mon_en) begin
      exp_valid = (q.size() != 0);
      exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
      check("out_valid", 64'(out_valid), 64'(exp_valid));
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("ovf_sticky", 64'(ovf_sticky), 64'(sticky_m));
      if (exp_valid) begin
        check("out_data", 64'(out_data), 64'(q[0].data));
        check("out_ch", 64'(out_ch), 64'(q[0].ch));
        check("out_last", 64'(out_last), 64'(q[0].last));
        check("out_ovf", 64'(out_ovf), 64'(q[0].ovf));
      end
      if (out_valid && out_ready) hs_cnt++;
      nxt = clr_ovf ? 1'b0 : sticky_m;
      if (exp_valid && out_ready) begin
        if (q[0].ovf) nxt = 1'b1;
        void'(q.pop_front());
      end
      sticky_m = nxt;
      if (in_valid && exp_ready) push_vector(in_data, round_en, sat_en);
    end
  end

  task automatic send_vec(input logic [CH*IN_W-1:0] d, input bit r, input bit s);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; round_en = r; sat_en = s;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=no_accept expected=accept at %0t", $time);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (q.size() == 0 && !out_valid) begin ok = 1'b0 | 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=pending expected=empty at %0t", $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic [CH*IN_W-1:0] rd;
    logic [OUT_W-1:0] held;
    bit o;
    int h0;

    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; round_en = 1'b0; sat_en = 1'b0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    d2_in_valid = 1'b0; d2_in_data = '0; d2_out_ready = 1'b1;

    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_sticky", 64'(ovf_sticky), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_ch", 64'(out_ch), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Hand-computed pins on the reference model.
    check("pin_0160_rnd", 64'(conv_model(sx16(16'h0160), 8, 8, 2, 1, 1, o)), 64'h06);
    check("pin_0160_trn", 64'(conv_model(sx16(16'h0160), 8, 8, 2, 0, 1, o)), 64'h05);
    check("pin_FEA0_rnd", 64'(conv_model(sx16(16'hFEA0), 8, 8, 2, 1, 1, o)), 64'hFB);
    check("pin_FEA0_trn", 64'(conv_model(sx16(16'hFEA0), 8, 8, 2, 0, 1, o)), 64'hFA);
    check("pin_4000_sat", 64'(conv_model(sx16(16'h4000), 8, 8, 2, 0, 1, o)), 64'h7F);
    check("pin_4000_ovf", 64'(o), 64'(1));
    check("pin_4000_wrap", 64'(conv_model(sx16(16'h4000), 8, 8, 2, 0, 0, o)), 64'h00);
    check("pin_C000_sat", 64'(conv_model(sx16(16'hC000), 8, 8, 2, 0, 1, o)), 64'h80);
    check("pin_7FFF_rs", 64'(conv_model(sx16(16'h7FFF), 8, 8, 2, 1, 1, o)), 64'h7F);
    check("pin_E8_ext", 64'(conv_model(sx8(8'hE8), 4, 16, 8, 0, 0, o)), 64'hFE80);
    check("pin_7F_ext", 64'(conv_model(sx8(8'h7F), 4, 16, 8, 0, 0, o)), 64'h07F0);

    // Widening instance: 8/4 -> 16/8, two channels.
    @(posedge clk); #1;
    d2_in_valid = 1'b1; d2_in_data = {8'h7F, 8'hE8};
    @(posedge clk); #1;
    d2_in_valid = 1'b0;
    @(negedge clk);
    check("d2_v0", 64'(d2_out_valid), 64'(1));
    check("d2_d0", 64'(d2_out_data), 64'hFE80);
    check("d2_last0", 64'(d2_out_last), 64'(0));
    check("d2_ovf0", 64'(d2_out_ovf), 64'(0));
    @(negedge clk);
    check("d2_d1", 64'(d2_out_data), 64'h07F0);
    check("d2_ch1", 64'(d2_out_ch), 64'(1));
    check("d2_last1", 64'(d2_out_last), 64'(1));
    check("d2_ovf1", 64'(d2_out_ovf), 64'(0));
    @(negedge clk);
    check("d2_idle", 64'(d2_out_valid), 64'(0));

    // Rounding, truncation, saturation, wrap.
    out_ready = 1'b1;
    send_vec({16'hC000, 16'h4000, 16'hFEA0, 16'h0160}, 1'b1, 1'b1);
    wait_drain();
    check("sticky_after_sat", 64'(ovf_sticky), 64'(1));
    send_vec({16'hC000, 16'h4000, 16'hFEA0, 16'h0160}, 1'b0, 1'b0);
    send_vec({16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000}, 1'b1, 1'b1);
    wait_drain();

    // Clear alone, then clear concurrent with an overflowing handshake.
    @(posedge clk); #1; clr_ovf = 1'b1;
    @(posedge clk); #1; clr_ovf = 1'b0;
    @(negedge clk);
    check("sticky_cleared", 64'(ovf_sticky), 64'(0));
    send_vec({16'h0000, 16'h4000, 16'h0000, 16'h0000}, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1; clr_ovf = 1'b1;
    @(posedge clk); #1; clr_ovf = 1'b0;
    @(negedge clk);
    check("sticky_set_wins", 64'(ovf_sticky), 64'(1));
    wait_drain();

    // Back-pressure on channel 1 for three cycles.
    send_vec({16'h0123, 16'hFF40, 16'h0200, 16'h0010}, 1'b0, 1'b1);
    @(posedge clk); #1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) held = out_data;
      check("hold_ch", 64'(out_ch), 64'(1));
      check("hold_data", 64'(out_data), 64'(held));
      check("hold_valid", 64'(out_valid), 64'(1));
    end
    @(posedge clk); #1; out_ready = 1'b1;
    wait_drain();

    // Two vectors back to back: eight samples in eight cycles.
    send_vec({16'h0001, 16'h0100, 16'hFF00, 16'h0040}, 1'b1, 1'b0);
    h0 = hs_cnt;
    fork
      send_vec({16'h1000, 16'hF000, 16'h0080, 16'h00C0}, 1'b1, 1'b1);
      begin repeat (8) @(negedge clk); #1; end
    join
    check("b2b_count", 64'(hs_cnt - h0), 64'(8));
    wait_drain();

    // Reset in the middle of a vector.
    send_vec({16'h4000, 16'h4000, 16'h4000, 16'h4000}, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_sticky", 64'(ovf_sticky), 64'(0));
    check("mid_rst_data", 64'(out_data), 64'(0));
    check("mid_rst_ch", 64'(out_ch), 64'(0));
    check("mid_rst_last", 64'(out_last), 64'(0));
    check("mid_rst_ovf", 64'(out_ovf), 64'(0));
    q.delete();
    sticky_m = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    send_vec({16'h0040, 16'h0080, 16'h00C0, 16'h0100}, 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_valid", 64'(out_valid), 64'(1));
    check("post_rst_ch", 64'(out_ch), 64'(0));
    wait_drain();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < CH; k++) begin
        v = 16'($urandom);
        if ($urandom_range(0, 1) == 1) v = {{6{v[9]}}, v[9:0]};
        rd[k*IN_W +: IN_W] = v;
      end
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = rd;
      round_en  = ($urandom_range(0, 1) == 1);
      sat_en    = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; clr_ovf = 1'b0; out_ready = 1'b1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conversor_formato.md
CONVERSOR_FORMATO -- requirements
Module: conversor_formato

Interface
REQ-001 Parameter CH, default 4: number of channels per input vector, >=1.
REQ-002 Parameter IN_W, default `ancho: input sample width, two's complement.
REQ-003 Parameter IN_FRAC, default `resolucion: input fractional bits, < IN_W.
REQ-004 Parameter OUT_W, default `dobleancho: output sample width, >=2.
REQ-005 Parameter OUT_FRAC, default 2*`resolucion: output fractional bits, < OUT_W.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset_n  in  1  reset, asynchronous, active-low.
REQ-008 in_valid  in  1  input vector offered.
REQ-009 in_ready  out  1  block can accept a vector this cycle.
REQ-010 in_data  in  CH*IN_W  channel k in bits [k*IN_W +: IN_W].
REQ-011 round_en  in  1  1 = round-half-up, 0 = truncate toward -inf; sampled with the vector.
REQ-012 sat_en  in  1  1 = saturate, 0 = wrap on integer overflow; sampled with the vector.
REQ-013 out_valid  out  1  converted sample present.
REQ-014 out_ready  in  1  consumer takes the sample.
REQ-015 out_data  out  OUT_W  converted sample.
REQ-016 out_ch  out  max(1,clog2(CH))  channel index of out_data.
REQ-017 out_last  out  1  high with the channel CH-1 sample.
REQ-018 out_ovf  out  1  this sample overflowed (saturated or wrapped).
REQ-019 ovf_sticky  out  1  OR of all out_ovf since reset or clear.
REQ-020 clr_ovf  in  1  synchronous clear of ovf_sticky.

Function
REQ-021 States IDLE and EMIT; IDLE->EMIT on accept; EMIT->IDLE on out_ready with out_last unless a new vector is accepted in the same cycle (then stay in EMIT, index 0).
REQ-022 Accept occurs when in_valid & in_ready; in_ready = (IDLE) | (EMIT & out_last & out_ready), giving back-to-back vectors with no bubble.
REQ-023 Accept registers in_data, round_en, sat_en and sets index to 0; out_valid rises the following cycle with channel 0 (latency 1).
REQ-024 In EMIT out_valid=1; index advances by 1 on each out_ready; out_data, out_ch, out_last, out_ovf hold stable while out_ready=0.
REQ-025 Fraction alignment: OUT_FRAC>=IN_FRAC appends OUT_FRAC-IN_FRAC zero LSBs; OUT_FRAC<IN_FRAC drops D=IN_FRAC-OUT_FRAC LSBs, adding 2^(D-1) first when round_en=1.
REQ-026 Rounding is computed one bit wider than the input so a carry is never lost before the range check.
REQ-027 Integer alignment: if the aligned value fits OUT_W it is sign-extended/copied exactly, out_ovf=0.
REQ-028 If it does not fit: sat_en=1 gives 0111..1 (positive) or 1000..0 (negative); sat_en=0 gives the low OUT_W bits; out_ovf=1 in both cases.
REQ-029 Default parameters reproduce the legacy alignment: sign extension into the upper integer bits and `resolucion zero LSBs, never overflowing.
REQ-030 ovf_sticky sets on any out_valid & out_ready & out_ovf; clr_ovf clears it; set wins when both occur in the same cycle.
REQ-031 No combinational path from in_data, round_en or sat_en to any output; out_* derive only from registers.

Reset
REQ-032 reset_n low, at any time including mid-vector, immediately forces IDLE, out_valid=0, out_ch=0, out_last=0, out_ovf=0, ovf_sticky=0, out_data=0, buffer cleared; in_ready=1 from the first edge after release; the interrupted vector is discarded.

Structure
REQ-033 `ancho, `resolucion, `dobleancho defaults and the IDLE/EMIT encoding live in constantes.h.
REQ-034 Per-sample arithmetic is a combinational sub-module convertidor_fx (one sample, round_en, sat_en in; value, ovf out), instantiated once and fed by the index-selected channel.

Verification
REQ-035 IN 8/4, OUT 16/8, CH=2: in 8'hE8, 8'h7F -> 16'hFE80, 16'h07F0, out_ovf=0, out_last on second.
REQ-036 IN 16/8, OUT 8/2: 16'h0160 -> 8'h06 (round_en=1), 8'h05 (round_en=0); 16'hFEA0 -> 8'hFB (round), 8'hFA (truncate).
REQ-037 IN 16/8, OUT 8/2: 16'h4000 -> 8'h7F (sat_en=1), 8'h00 (sat_en=0), out_ovf=1, ovf_sticky=1; 16'hC000 sat -> 8'h80; 16'h7FFF round+sat -> 8'h7F.
REQ-038 CH=4, out_ready low 3 cycles on channel 1 -> outputs frozen, no channel lost or repeated; two vectors with out_ready=1 -> 8 samples in 8 consecutive cycles.
REQ-039 reset_n low during channel 2 -> out_valid=0 asynchronously, ovf_sticky=0; next vector starts at out_ch=0; clr_ovf with a concurrent overflow -> ovf_sticky stays 1.
